// File: rtl/hms_timer.sv
// Hours/minutes/seconds timer with run-time count direction, field editing
// and a self-clearing alarm state. Presents {hh,mm,ss} as binary fields.
module hms_timer #(
  parameter int CLK_HZ    = 50000000,
  parameter int HOUR_MAX  = 23,
  parameter int ALARM_SEC = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        active,
  input  logic        dir,
  input  logic [3:0]  button,
  output logic [23:0] data_t,
  output logic [3:0]  led,
  output logic        sec_tick,
  output logic        done,
  output logic [2:0]  dbg_state_o
);

  localparam int PW = $clog2(CLK_HZ);
  localparam int AW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_HZ - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'((ALARM_SEC > 0) ? ALARM_SEC - 1 : 0);
  localparam logic [7:0]    HMAX       = 8'(HOUR_MAX);
  localparam logic [7:0]    MS_MAX     = 8'd59;

  typedef enum logic [2:0] {
    S_STOP     = 3'd0,
    S_RUN      = 3'd1,
    S_SET_SEC  = 3'd2,
    S_SET_MIN  = 3'd3,
    S_SET_HOUR = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [AW-1:0]   alarm_q, alarm_d;
  logic [7:0]      hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic [3:0]      button_q;
  logic            tick_q, tick_d, done_q, done_d;

  logic [3:0]      press;
  logic            act3, act2, act1, act0, any_press;
  logic            term, is_zero, step_zero;
  logic [7:0]      step_hh, step_mm, step_ss;

  function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [7:0] top);
    return (v == top) ? 8'd0 : v + 8'd1;
  endfunction

  function automatic logic [7:0] wrap_dec(input logic [7:0] v, input logic [7:0] top);
    return (v == 8'd0) ? top : v - 8'd1;
  endfunction

  // One action per cycle: the highest-numbered rising button wins.
  assign press     = active ? (button & ~button_q) : 4'b0000;
  assign act3      = press[3];
  assign act2      = press[2] & ~press[3];
  assign act1      = press[1] & ~(|press[3:2]);
  assign act0      = press[0] & ~(|press[3:1]);
  assign any_press = |press;
  assign term      = (pre_q == PRE_LAST);
  assign is_zero   = (hh_q == 8'd0) && (mm_q == 8'd0) && (ss_q == 8'd0);

  always_comb begin
    step_hh = hh_q;
    step_mm = mm_q;
    step_ss = ss_q;
    if (dir) begin
      step_ss = wrap_inc(ss_q, MS_MAX);
      if (ss_q == MS_MAX) begin
        step_mm = wrap_inc(mm_q, MS_MAX);
        if (mm_q == MS_MAX) step_hh = wrap_inc(hh_q, HMAX);
      end
    end else begin
      step_ss = wrap_dec(ss_q, MS_MAX);
      if (ss_q == 8'd0) begin
        step_mm = wrap_dec(mm_q, MS_MAX);
        if (mm_q == 8'd0) step_hh = wrap_dec(hh_q, HMAX);
      end
    end
  end

  // Zero after a step means countdown expiry (down) or full rollover (up).
  assign step_zero = (step_hh == 8'd0) && (step_mm == 8'd0) && (step_ss == 8'd0);

  always_comb begin
    state_d = state_q;
    pre_d   = '0;
    alarm_d = alarm_q;
    hh_d    = hh_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_STOP: begin
        if (act3) begin
          if (dir || !is_zero) state_d = S_RUN;
        end else if (act2) begin
          state_d = S_SET_SEC;
        end
      end
      S_SET_SEC: begin
        if (act2)      state_d = S_SET_MIN;
        else if (act1) ss_d = wrap_inc(ss_q, MS_MAX);
        else if (act0) ss_d = wrap_dec(ss_q, MS_MAX);
      end
      S_SET_MIN: begin
        if (act2)      state_d = S_SET_HOUR;
        else if (act1) mm_d = wrap_inc(mm_q, MS_MAX);
        else if (act0) mm_d = wrap_dec(mm_q, MS_MAX);
      end
      S_SET_HOUR: begin
        if (act2)      state_d = S_STOP;
        else if (act1) hh_d = wrap_inc(hh_q, HMAX);
        else if (act0) hh_d = wrap_dec(hh_q, HMAX);
      end
      S_RUN: begin
        if (act3) begin
          state_d = S_STOP;
        end else begin
          pre_d = term ? '0 : pre_q + PW'(1);
          if (term) begin
            tick_d = 1'b1;
            hh_d   = step_hh;
            mm_d   = step_mm;
            ss_d   = step_ss;
            done_d = step_zero;
            if (step_zero && !dir) begin
              state_d = S_DONE;
              alarm_d = '0;
            end
          end
        end
      end
      S_DONE: begin
        if (any_press) begin
          state_d = S_STOP;
        end else begin
          pre_d = term ? '0 : pre_q + PW'(1);
          if (term) begin
            tick_d = 1'b1;
            if (ALARM_SEC > 0) begin
              if (alarm_q == ALARM_LAST) state_d = S_STOP;
              else                       alarm_d = alarm_q + AW'(1);
            end
          end
        end
      end
      default: state_d = S_STOP;
    endcase
  end

  always_ff @(posedge clock) begin
    button_q <= button;
    if (reset) begin
      state_q <= S_STOP;
      pre_q   <= '0;
      alarm_q <= '0;
      hh_q    <= 8'd0;
      mm_q    <= 8'd0;
      ss_q    <= 8'd0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      alarm_q <= alarm_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    led = 4'b0000;
    case (state_q)
      S_RUN:      led = 4'b0001;
      S_SET_SEC:  led = 4'b0010;
      S_SET_MIN:  led = 4'b0100;
      S_SET_HOUR: led = 4'b1000;
      S_DONE:     led = 4'b1111;
      default:    led = 4'b0000;
    endcase
  end

  assign data_t      = {hh_q, mm_q, ss_q};
  assign sec_tick    = tick_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hms_timer.sv
// Directed bench for hms_timer (CLK_HZ=4, HOUR_MAX=23, ALARM_SEC=2): the
// driver schedules expected observations; a monitor compares them by cycle.
module tb_hms_timer;

  localparam int W = 33;
  localparam logic [2:0] ST_STOP = 3'd0, ST_RUN = 3'd1, ST_SSEC = 3'd2,
                         ST_SMIN = 3'd3, ST_SHOUR = 3'd4, ST_DONE = 3'd5;
  localparam logic [3:0] B_START = 4'b1000, B_SEL = 4'b0100,
                         B_INC = 4'b0010, B_DEC = 4'b0001;

  logic        clock = 1'b0;
  logic        reset, active, dir;
  logic [3:0]  button;
  logic [23:0] data_t;
  logic [3:0]  led;
  logic        sec_tick, done;
  logic [2:0]  dbg_state_o;

  logic [W-1:0] exp_q[$];
  int           cyc_q[$];
  string        name_q[$];
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;

  hms_timer #(.CLK_HZ(4), .HOUR_MAX(23), .ALARM_SEC(2)) dut (
    .clock(clock), .reset(reset), .active(active), .dir(dir),
    .button(button), .data_t(data_t), .led(led), .sec_tick(sec_tick),
    .done(done), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  function automatic logic [W-1:0] obs(input int h, input int m, input int s,
                                       input logic [3:0] l, input logic t,
                                       input logic d, input logic [2:0] st);
    return {8'(h), 8'(m), 8'(s), l, t, d, st};
  endfunction

  task automatic expect_at(input int k, input logic [W-1:0] v, input string name);
    exp_q.push_back(v);
    cyc_q.push_back(cyc + k);
    name_q.push_back(name);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input logic [3:0] b);
    button = b;
    tick(1);
    button = 4'b0000;
    tick(1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    expect_at(1, obs(0, 0, 0, 4'h0, 1'b0, 1'b0, ST_STOP), "reset_clear");
    tick(1);
  endtask

  task automatic set_field(input int v, input int top);
    if (v <= top / 2) repeat (v) press(B_INC);
    else              repeat (top + 1 - v) press(B_DEC);
  endtask

  // Starts from STOP with 00:00:00 and ends in STOP.
  task automatic set_time(input int h, input int m, input int s);
    press(B_SEL);
    set_field(s, 59);
    press(B_SEL);
    set_field(m, 59);
    press(B_SEL);
    set_field(h, 23);
    press(B_SEL);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] act;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      act = {data_t, led, sec_tick, done, dbg_state_o};
      for (int i = cyc_q.size() - 1; i >= 0; i--) begin
        if (cyc_q[i] == cyc) begin
          total++;
          if (act !== exp_q[i]) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h (data_t,led,tick,done,state)",
                     name_q[i], cyc, act, exp_q[i]);
          end
          cyc_q.delete(i);
          exp_q.delete(i);
          name_q.delete(i);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset  = 1'b1;
    active = 1'b1;
    dir    = 1'b0;
    button = B_START;
    tick(3);

    // Start button held through reset must not start the timer.
    reset = 1'b0;
    for (int i = 1; i <= 5; i++)
      expect_at(i, obs(0, 0, 0, 4'h0, 1'b0, 1'b0, ST_STOP), "reset_hold");
    tick(5);
    total++;
    if (dbg_state_o !== ST_STOP || led !== 4'h0 || data_t !== 24'h000000) begin
      bad++;
      $display("FAIL reset_hold_direct state=%0d led=%h data_t=%h", dbg_state_o, led, data_t);
    end
    button = 4'b0000;
    tick(1);

    // Field edit sequence.
    expect_at(1, obs(0, 0, 0, 4'b0010, 1'b0, 1'b0, ST_SSEC), "edit_enter_sec");
    press(B_SEL);
    press(B_INC); press(B_INC);
    expect_at(1, obs(0, 0, 3, 4'b0010, 1'b0, 1'b0, ST_SSEC), "edit_inc_sec");
    press(B_INC);
    press(B_SEL);
    expect_at(1, obs(0, 59, 3, 4'b0100, 1'b0, 1'b0, ST_SMIN), "edit_dec_wrap_min");
    press(B_DEC);
    press(B_SEL);
    press(B_INC); press(B_INC);
    expect_at(1, obs(2, 59, 3, 4'h0, 1'b0, 1'b0, ST_STOP), "edit_final");
    press(B_SEL);
    tick(1);
    total++;
    if (data_t !== {8'd2, 8'd59, 8'd3} || led !== 4'h0 || dbg_state_o !== ST_STOP) begin
      bad++;
      $display("FAIL edit_final_direct data_t=%h led=%h state=%0d", data_t, led, dbg_state_o);
    end

    // Countdown 00:00:02 through DONE and alarm timeout.
    do_reset();
    set_time(0, 0, 2);
    dir = 1'b0;
    expect_at(1,  obs(0, 0, 2, 4'h1, 1'b0, 1'b0, ST_RUN),  "cd_run");
    expect_at(4,  obs(0, 0, 2, 4'h1, 1'b0, 1'b0, ST_RUN),  "cd_before_step");
    expect_at(5,  obs(0, 0, 1, 4'h1, 1'b1, 1'b0, ST_RUN),  "cd_step1");
    expect_at(6,  obs(0, 0, 1, 4'h1, 1'b0, 1'b0, ST_RUN),  "cd_tick_pulse");
    expect_at(9,  obs(0, 0, 0, 4'hF, 1'b1, 1'b1, ST_DONE), "cd_expire");
    expect_at(10, obs(0, 0, 0, 4'hF, 1'b0, 1'b0, ST_DONE), "cd_done_pulse");
    expect_at(13, obs(0, 0, 0, 4'hF, 1'b1, 1'b0, ST_DONE), "cd_done_tick");
    expect_at(16, obs(0, 0, 0, 4'hF, 1'b0, 1'b0, ST_DONE), "cd_still_done");
    expect_at(18, obs(0, 0, 0, 4'h0, 1'b0, 1'b0, ST_STOP), "cd_alarm_timeout");
    press(B_START);
    tick(17);
    total++;
    if (dbg_state_o !== ST_STOP || led !== 4'h0) begin
      bad++;
      $display("FAIL cd_timeout_direct state=%0d led=%h", dbg_state_o, led);
    end

    // Countdown start refused at zero.
    expect_at(1, obs(0, 0, 0, 4'h0, 1'b0, 1'b0, ST_STOP), "start_zero_blocked");
    expect_at(3, obs(0, 0, 0, 4'h0, 1'b0, 1'b0, ST_STOP), "start_zero_blocked2");
    press(B_START);
    tick(2);

    // Borrow across hour and minute, then stop freezes the value.
    set_time(1, 0, 0);
    expect_at(5, obs(0, 59, 59, 4'h1, 1'b1, 1'b0, ST_RUN), "borrow");
    press(B_START);
    tick(3);
    expect_at(1, obs(0, 59, 59, 4'h0, 1'b0, 1'b0, ST_STOP), "stop_freeze");
    expect_at(6, obs(0, 59, 59, 4'h0, 1'b0, 1'b0, ST_STOP), "stop_hold");
    press(B_START);
    tick(5);

    // Up-count rollover, inactive buttons, dir change, exit DONE by press.
    do_reset();
    set_time(23, 59, 59);
    dir = 1'b1;
    expect_at(1, obs(23, 59, 59, 4'h1, 1'b0, 1'b0, ST_RUN), "up_run");
    expect_at(5, obs(0, 0, 0, 4'h1, 1'b1, 1'b1, ST_RUN),    "rollover");
    expect_at(6, obs(0, 0, 0, 4'h1, 1'b0, 1'b0, ST_RUN),    "rollover_stays_run");
    press(B_START);
    tick(4);
    active = 1'b0;
    expect_at(3, obs(0, 0, 1, 4'h1, 1'b1, 1'b0, ST_RUN), "inactive_keeps_run");
    press(B_START);
    active = 1'b1;
    tick(1);
    dir = 1'b0;
    expect_at(4, obs(0, 0, 0, 4'hF, 1'b1, 1'b1, ST_DONE), "dir_change_to_done");
    tick(4);
    expect_at(1, obs(0, 0, 0, 4'h0, 1'b0, 1'b0, ST_STOP), "done_press_exit");
    press(B_INC);
    tick(1);

    // Start/select priority, then stop on the terminal-count cycle.
    do_reset();
    set_time(0, 0, 5);
    dir = 1'b1;
    expect_at(1, obs(0, 0, 5, 4'h1, 1'b0, 1'b0, ST_RUN), "prio_run_only");
    press(B_START | B_SEL);
    tick(2);
    expect_at(1, obs(0, 0, 5, 4'h0, 1'b0, 1'b0, ST_STOP), "stop_at_terminal");
    expect_at(2, obs(0, 0, 5, 4'h0, 1'b0, 1'b0, ST_STOP), "stop_at_terminal_hold");
    press(B_START);
    tick(1);

    // Reset in the middle of an edit.
    press(B_SEL);
    press(B_INC);
    expect_at(1, obs(0, 0, 0, 4'h0, 1'b0, 1'b0, ST_STOP), "reset_mid_edit");
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(3);

    for (int i = 0; i < cyc_q.size(); i++) begin
      bad++;
      $display("FAIL %s never_checked target_cyc=%0d want=%h", name_q[i], cyc_q[i], exp_q[i]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad == 0 && total > 0) $display("PASS");
    else                       $display("FAIL");
    $finish;
  end

endmodule

// File: doc/hms_timer.md
# hms_timer

Parametrised hours/minutes/seconds timer for the clock design, replacing the fixed 50 MHz countdown timer. It selects count direction at run time, edits fields with increment and decrement, raises an alarm with automatic timeout, and drives tick and done pulses for the display and buzzer logic. It sits beside the display mux, takes the shared debounced button bus, and presents {hh,mm,ss} in the existing 24-bit layout.

## Interface
- CLK_HZ, 50000000, clock cycles per second; must be ≥ 2; prescaler width is $clog2(CLK_HZ).
- HOUR_MAX, 23, terminal hour value, 1..255.
- ALARM_SEC, 10, seconds spent in DONE before auto-return to STOP; 0 = stay in DONE until a press.
- clock  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- active  in  1  the block owns the buttons when 1; presses are ignored when 0, counting continues.
- dir  in  1  0 = count down, 1 = count up; sampled on every second step.
- button  in  4  synchronous, debounced levels; [3] start/stop, [2] field select, [1] increment, [0] decrement.
- data_t  out  24  {hh[23:16], mm[15:8], ss[7:0]}, binary per field, registered.
- led  out  4  [0] running, [1] set-sec, [2] set-min, [3] set-hour; 4'hF in DONE.
- sec_tick  out  1  one-cycle pulse per counted second.
- done  out  1  one-cycle pulse on countdown expiry or count-up rollover.

## Operation
- Button presses are rising edges: press = button & ~button_q. During reset, button_q loads button, so a button held through reset produces no press.
- Only one press acts per cycle, in priority order [3] > [2] > [1] > [0]. All presses are ignored when active=0.
- States: STOP, RUN, SET_SEC, SET_MIN, SET_HOUR, DONE. The reset state is STOP.
- STOP:
  - press[3] enters RUN, unless dir=0 and data_t==0; in that case it stays in STOP.
  - press[2] enters SET_SEC.
  - press[1] and press[0] are ignored.
- SET_SEC, SET_MIN and SET_HOUR:
  - press[1] increments the selected field with wrap: ss and mm go 59→0, hh goes HOUR_MAX→0.
  - press[0] decrements with wrap: 0→59 for ss and mm, 0→HOUR_MAX for hh.
  - press[2] advances SET_SEC→SET_MIN→SET_HOUR→STOP.
  - press[3] is ignored.
- RUN:
  - The prescaler counts 0..CLK_HZ-1. At the terminal count the block steps data_t by one second and pulses sec_tick.
  - Down step: ss decrements; at ss=0, ss becomes 59 and mm borrows; at mm=0, mm becomes 59 and hh borrows. A step that produces 00:00:00 pulses done and moves to DONE.
  - Up step: ss increments; at ss=59, ss becomes 0 and mm carries; at mm=59, mm becomes 0 and hh carries. From HOUR_MAX:59:59 the value wraps to 00:00:00, done pulses, and the block stays in RUN.
  - press[3] moves to STOP and freezes data_t. press[2], press[1] and press[0] are ignored.
- DONE:
  - led=4'hF and data_t holds 0.
  - Any press (active=1) returns to STOP.
  - If ALARM_SEC>0, the block returns to STOP after ALARM_SEC prescaler periods. The prescaler keeps running in DONE, and sec_tick keeps pulsing.
- Fields never hold out-of-range values; no path loads external data.

## Timing
- Reset values: data_t=0, led=0, sec_tick=0, done=0, prescaler=0, alarm counter=0, state STOP.
- Press latency: a button rise sampled at edge n updates the state, led and edited field at edge n+1.
- The prescaler clears on every entry to RUN and DONE. The first step lands exactly CLK_HZ cycles after the cycle in which RUN becomes visible on led[0].
- sec_tick, done and the new data_t change together at the same edge.
- A press[3] in the same cycle as a terminal count wins: no step occurs and the state becomes STOP.
- A dir change takes effect at the next step only.
- reset in any state returns to the reset values at the next edge, including mid-edit and mid-alarm.

## Test plan
- Reset hold: button=4'b1000 held through reset and for 5 cycles after it → state STOP, led=0, data_t=0, no RUN.
- Edit (CLK_HZ=4, active=1): press [2], [1]×3, [2], [0]×1, [2], [1]×2, [2] → data_t={8'd2,8'd59,8'd3}, led=0, state STOP.
- Countdown (CLK_HZ=4, ALARM_SEC=2): preset 00:00:02, dir=0, press [3]:
  - 4 cycles after led[0] rises, data_t=00:00:01 with sec_tick=1.
  - 8 cycles after led[0] rises, data_t=00:00:00, done=1 for one cycle, led=4'hF.
  - 8 cycles later, led=0 and the state is STOP.
- Borrow and rollover:
  - 01:00:00 with dir=0 → 00:59:59 after one step.
  - HOUR_MAX=23, 23:59:59 with dir=1 → 00:00:00, done=1, led[0] stays 1.
- Priority and active:
  - In STOP, [3] and [2] rise together → RUN only.
  - While in RUN, active=0 and press [3] → keeps counting.
  - dir=0 at 00:00:00 and press [3] → stays STOP.
- Stop at terminal count: press[3] lands in the prescaler-terminal cycle → STOP, data_t unchanged, sec_tick=0.
